// File: rtl/ctrl_sched_pkg.sv
// Shared types and constants for the socket launch scheduler.
package ctrl_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_ISSUE = 3'd1,
    S_W_WAIT  = 3'd2,
    S_GAP     = 3'd3,
    S_R_ISSUE = 3'd4,
    S_R_WAIT  = 3'd5,
    S_FIN     = 3'd6
  } sched_state_e;

  localparam int unsigned STATUS_DONE_BIT    = 0;
  localparam logic [63:0] DEF_SOCKET_STRIDE  = 64'h0000_0000_0001_0000;
  localparam logic [63:0] DEF_CTRL_REG_OFS   = 64'h0;
  localparam logic [63:0] DEF_STATUS_REG_OFS = 64'h10;

  // Launch parameters captured on an accepted start.
  typedef struct packed {
    logic [63:0] base;
    logic [31:0] word;
  } launch_cfg_t;

  // Socket index width; at least one bit even for a single socket.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/socket_launch_sched_if.sv
// Single-beat control-master start/done bus as seen by the scheduler.
interface socket_launch_sched_if;
  logic        sched_rstart;
  logic        sched_wstart;
  logic        sched_rdone;
  logic        sched_wdone;
  logic [31:0] sched_rdata;
  logic [31:0] sched_wdata;
  logic [63:0] sched_offset;
  logic        sched_running;

  modport master (
    output sched_rstart, sched_wstart, sched_wdata, sched_offset,
    input  sched_rdone, sched_wdone, sched_rdata, sched_running
  );

  modport slave (
    input  sched_rstart, sched_wstart, sched_wdata, sched_offset,
    output sched_rdone, sched_wdone, sched_rdata, sched_running
  );
endinterface

// File: rtl/socket_rr_pick.sv
// Finds the next set mask bit strictly above idx, optionally wrapping to the lowest.
module socket_rr_pick
  import ctrl_sched_pkg::*;
#(
  parameter  int unsigned NUM_SOCKETS = 4,
  localparam int unsigned IDX_W       = idx_width(NUM_SOCKETS)
) (
  input  logic [NUM_SOCKETS-1:0] i_mask,
  input  logic [IDX_W-1:0]       i_idx,
  input  logic                   i_wrap,
  output logic [IDX_W-1:0]       o_next_c,
  output logic                   o_found_c
);

  logic             w_hi_hit;
  logic             w_lo_hit;
  logic [IDX_W-1:0] w_hi;
  logic [IDX_W-1:0] w_lo;

  // Descending scan: the last hit written is the lowest qualifying bit.
  always_comb begin
    w_hi_hit = 1'b0;
    w_lo_hit = 1'b0;
    w_hi     = '0;
    w_lo     = '0;
    for (int i = NUM_SOCKETS - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        w_lo_hit = 1'b1;
        w_lo     = IDX_W'(i);
        if (IDX_W'(i) > i_idx) begin
          w_hi_hit = 1'b1;
          w_hi     = IDX_W'(i);
        end
      end
    end
  end

  assign o_next_c  = (i_wrap && !w_hi_hit) ? w_lo : w_hi;
  assign o_found_c = w_hi_hit | (i_wrap & w_lo_hit);

endmodule

// File: rtl/socket_launch_sched.sv
// Writes a start word to each enabled socket, then round-robin polls status until all are done.
module socket_launch_sched
  import ctrl_sched_pkg::*;
#(
  parameter int unsigned NUM_SOCKETS    = 4,
  parameter logic [63:0] SOCKET_STRIDE  = DEF_SOCKET_STRIDE,
  parameter logic [63:0] CTRL_REG_OFS   = DEF_CTRL_REG_OFS,
  parameter logic [63:0] STATUS_REG_OFS = DEF_STATUS_REG_OFS,
  parameter int unsigned POLL_GAP       = 16,
  parameter int unsigned MAX_POLLS      = 4096
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   launch_start,
  input  logic [NUM_SOCKETS-1:0] launch_mask,
  input  logic [63:0]            launch_base,
  input  logic [31:0]            launch_word,
  output logic                   launch_busy,
  output logic                   launch_done,
  output logic                   launch_err,
  output logic [NUM_SOCKETS-1:0] done_mask,
  socket_launch_sched_if.master  bus
);

  localparam int unsigned IDX_W  = idx_width(NUM_SOCKETS);
  localparam int unsigned GAP_W  = $clog2(POLL_GAP + 1);
  localparam int unsigned POLL_W = $clog2(MAX_POLLS + 1);

  sched_state_e           r_state, w_state_nxt;
  logic [NUM_SOCKETS-1:0] r_mask, w_mask_nxt;
  launch_cfg_t            r_cfg, w_cfg_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [NUM_SOCKETS-1:0] r_done_mask, w_done_mask_nxt;
  logic                   r_err, w_err_nxt;
  logic [POLL_W-1:0]      r_poll_cnt, w_poll_nxt;
  logic [GAP_W-1:0]       r_gap_cnt, w_gap_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_rstart, w_rstart_nxt;
  logic                   r_wstart, w_wstart_nxt;
  logic [63:0]            r_offset, w_offset_nxt;
  logic                   r_rdone_q, r_wdone_q;

  logic                   w_redge, w_wedge, w_can_read, w_can_write;
  logic [63:0]            w_ctrl_addr, w_stat_addr;
  logic [NUM_SOCKETS-1:0] w_done_mask_upd, w_pending_upd;
  logic [NUM_SOCKETS-1:0] w_pp_mask;
  logic [IDX_W-1:0]       w_pp_idx, w_pp_next, w_wr_next;
  logic                   w_wr_found, w_unused_pp_found, w_unused_rdata;

  assign w_redge     = bus.sched_rdone & ~r_rdone_q;
  assign w_wedge     = bus.sched_wdone & ~r_wdone_q;
  assign w_can_read  = ~bus.sched_running & ~bus.sched_rdone;
  assign w_can_write = ~bus.sched_running & ~bus.sched_wdone;
  assign w_ctrl_addr = r_cfg.base + 64'(r_idx) * SOCKET_STRIDE + CTRL_REG_OFS;
  assign w_stat_addr = r_cfg.base + 64'(r_idx) * SOCKET_STRIDE + STATUS_REG_OFS;
  assign w_done_mask_upd = r_done_mask |
    (bus.sched_rdata[STATUS_DONE_BIT] ? (NUM_SOCKETS'(1) << r_idx) : '0);
  assign w_pending_upd  = r_mask & ~w_done_mask_upd;
  assign w_unused_rdata = ^bus.sched_rdata;

  // Poll walker input: lowest set bit when starting a walk, else next pending after idx.
  always_comb begin
    w_pp_mask = w_pending_upd;
    w_pp_idx  = r_idx;
    if (r_state == S_IDLE) begin
      w_pp_mask = launch_mask;
      w_pp_idx  = IDX_W'(NUM_SOCKETS - 1);
    end else if (r_state == S_W_WAIT) begin
      w_pp_mask = r_mask & ~r_done_mask;
      w_pp_idx  = IDX_W'(NUM_SOCKETS - 1);
    end
  end

  socket_rr_pick #(.NUM_SOCKETS(NUM_SOCKETS)) u_wr_pick (
    .i_mask    (r_mask),
    .i_idx     (r_idx),
    .i_wrap    (1'b0),
    .o_next_c  (w_wr_next),
    .o_found_c (w_wr_found)
  );

  socket_rr_pick #(.NUM_SOCKETS(NUM_SOCKETS)) u_poll_pick (
    .i_mask    (w_pp_mask),
    .i_idx     (w_pp_idx),
    .i_wrap    (1'b1),
    .o_next_c  (w_pp_next),
    .o_found_c (w_unused_pp_found)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_mask_nxt      = r_mask;
    w_cfg_nxt       = r_cfg;
    w_idx_nxt       = r_idx;
    w_done_mask_nxt = r_done_mask;
    w_err_nxt       = r_err;
    w_poll_nxt      = r_poll_cnt;
    w_gap_nxt       = r_gap_cnt;
    w_busy_nxt      = 1'b1;
    w_done_nxt      = 1'b0;
    w_rstart_nxt    = 1'b0;
    w_wstart_nxt    = 1'b0;
    w_offset_nxt    = r_offset;
    unique case (r_state)
      S_IDLE: begin
        // Busy still covers the done-pulse cycle, so a start there is dropped.
        w_busy_nxt = 1'b0;
        if (launch_start && !r_busy) begin
          w_busy_nxt      = 1'b1;
          w_mask_nxt      = launch_mask;
          w_cfg_nxt.base  = launch_base;
          w_cfg_nxt.word  = launch_word;
          w_done_mask_nxt = '0;
          w_err_nxt       = 1'b0;
          w_poll_nxt      = '0;
          if (launch_mask == '0) begin
            w_state_nxt = S_FIN;
          end else begin
            w_idx_nxt   = w_pp_next;
            w_state_nxt = S_W_ISSUE;
          end
        end
      end
      S_W_ISSUE: begin
        if (w_can_write) begin
          w_wstart_nxt = 1'b1;
          w_offset_nxt = w_ctrl_addr;
          w_state_nxt  = S_W_WAIT;
        end
      end
      S_W_WAIT: begin
        if (w_wedge) begin
          if (w_wr_found) begin
            w_idx_nxt   = w_wr_next;
            w_state_nxt = S_W_ISSUE;
          end else begin
            w_idx_nxt   = w_pp_next;
            w_gap_nxt   = '0;
            w_state_nxt = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_W'(POLL_GAP - 1)) begin
          w_state_nxt = S_R_ISSUE;
        end else begin
          w_gap_nxt = r_gap_cnt + GAP_W'(1);
        end
      end
      S_R_ISSUE: begin
        if (w_can_read) begin
          w_rstart_nxt = 1'b1;
          w_offset_nxt = w_stat_addr;
          w_poll_nxt   = r_poll_cnt + POLL_W'(1);
          w_state_nxt  = S_R_WAIT;
        end
      end
      S_R_WAIT: begin
        if (w_redge) begin
          w_done_mask_nxt = w_done_mask_upd;
          if (w_pending_upd == '0) begin
            w_state_nxt = S_FIN;
          end else if (r_poll_cnt == POLL_W'(MAX_POLLS)) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_FIN;
          end else begin
            w_idx_nxt   = w_pp_next;
            w_gap_nxt   = '0;
            w_state_nxt = S_GAP;
          end
        end
      end
      S_FIN: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_cfg       <= '0;
      r_idx       <= '0;
      r_done_mask <= '0;
      r_err       <= 1'b0;
      r_poll_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rstart    <= 1'b0;
      r_wstart    <= 1'b0;
      r_offset    <= '0;
      r_rdone_q   <= 1'b0;
      r_wdone_q   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mask      <= w_mask_nxt;
      r_cfg       <= w_cfg_nxt;
      r_idx       <= w_idx_nxt;
      r_done_mask <= w_done_mask_nxt;
      r_err       <= w_err_nxt;
      r_poll_cnt  <= w_poll_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_rstart    <= w_rstart_nxt;
      r_wstart    <= w_wstart_nxt;
      r_offset    <= w_offset_nxt;
      r_rdone_q   <= bus.sched_rdone;
      r_wdone_q   <= bus.sched_wdone;
    end
  end

  assign launch_busy      = r_busy;
  assign launch_done      = r_done;
  assign launch_err       = r_err;
  assign done_mask        = r_done_mask;
  assign bus.sched_rstart = r_rstart;
  assign bus.sched_wstart = r_wstart;
  assign bus.sched_wdata  = r_cfg.word;
  assign bus.sched_offset = r_offset;

endmodule

// File: tb/tb_socket_launch_sched.sv
// Directed bench: behavioural control-master model plus hand-computed expectations.
module tb_socket_launch_sched;

  logic        clk;
  logic        resetn;
  logic        launch_start;
  logic [3:0]  launch_mask;
  logic [63:0] launch_base;
  logic [31:0] launch_word;
  logic        launch_busy;
  logic        launch_done;
  logic        launch_err;
  logic [3:0]  done_mask;

  socket_launch_sched_if sched_bus ();

  socket_launch_sched #(
    .NUM_SOCKETS    (4),
    .SOCKET_STRIDE  (64'h0000_0000_0001_0000),
    .CTRL_REG_OFS   (64'h0),
    .STATUS_REG_OFS (64'h10),
    .POLL_GAP       (4),
    .MAX_POLLS      (5)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .launch_start (launch_start),
    .launch_mask  (launch_mask),
    .launch_base  (launch_base),
    .launch_word  (launch_word),
    .launch_busy  (launch_busy),
    .launch_done  (launch_done),
    .launch_err   (launch_err),
    .done_mask    (done_mask),
    .bus          (sched_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  // Test controls (written only by the stimulus block).
  logic        clr;
  logic [63:0] cur_base;
  int          need [4];

  // Observations (written only by the model/monitor block).
  logic [63:0] wr_ofs [$];
  logic [31:0] wr_dat [$];
  logic [63:0] rd_ofs [$];
  int          rd_cyc [$];
  int          rd_cnt [4];
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          n_done = 0;
  logic        done_err_s;
  logic [3:0]  done_mask_s;
  logic        done_busy_s;
  int          m_lat = 0;
  int          m_hold = 0;
  logic        m_is_rd;
  logic        m_bit;
  logic [63:0] m_rel;
  logic [1:0]  m_sock;

  int k;
  int min_gap;

  // Control-master model (3-cycle latency, done held 2 cycles) and bus monitor.
  always @(negedge clk) begin
    if (!resetn) begin
      sched_bus.sched_rdone   = 1'b0;
      sched_bus.sched_wdone   = 1'b0;
      sched_bus.sched_running = 1'b0;
      sched_bus.sched_rdata   = 32'd0;
      m_lat  = 0;
      m_hold = 0;
    end else begin
      if (clr) begin
        wr_ofs.delete();
        wr_dat.delete();
        rd_ofs.delete();
        rd_cyc.delete();
        n_done = 0;
        foreach (rd_cnt[i]) rd_cnt[i] = 0;
      end
      if (launch_start) start_cyc = cyc;
      if (launch_done) begin
        n_done++;
        done_cyc    = cyc;
        done_err_s  = launch_err;
        done_mask_s = done_mask;
        done_busy_s = launch_busy;
      end
      if (m_hold != 0) begin
        m_hold--;
        if (m_hold == 0) begin
          sched_bus.sched_rdone = 1'b0;
          sched_bus.sched_wdone = 1'b0;
        end
      end
      if (m_lat != 0) begin
        m_lat--;
        if (m_lat == 0) begin
          sched_bus.sched_running = 1'b0;
          m_hold = 2;
          if (m_is_rd) begin
            sched_bus.sched_rdata = {31'd0, m_bit};
            sched_bus.sched_rdone = 1'b1;
          end else begin
            sched_bus.sched_wdone = 1'b1;
          end
        end
      end
      if (sched_bus.sched_wstart) begin
        wr_ofs.push_back(sched_bus.sched_offset);
        wr_dat.push_back(sched_bus.sched_wdata);
        m_is_rd = 1'b0;
        m_lat   = 3;
        sched_bus.sched_running = 1'b1;
      end
      if (sched_bus.sched_rstart) begin
        rd_ofs.push_back(sched_bus.sched_offset);
        rd_cyc.push_back(cyc);
        m_rel  = sched_bus.sched_offset - cur_base;
        m_sock = 2'(m_rel >> 16);
        rd_cnt[m_sock]++;
        m_bit   = (need[m_sock] != 0) && (rd_cnt[m_sock] >= need[m_sock]);
        m_is_rd = 1'b1;
        m_lat   = 3;
        sched_bus.sched_running = 1'b1;
      end
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [3:0] m, input logic [63:0] b, input logic [31:0] w);
    @(posedge clk); #1;
    cur_base     = b;
    clr          = 1'b1;
    launch_start = 1'b1;
    launch_mask  = m;
    launch_base  = b;
    launch_word  = w;
    @(posedge clk); #1;
    clr          = 1'b0;
    launch_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (n_done == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(tag, 64'(n_done != 0), 64'd1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    resetn       = 1'b0;
    launch_start = 1'b0;
    launch_mask  = 4'h0;
    launch_base  = 64'h0;
    launch_word  = 32'h0;
    clr          = 1'b0;
    cur_base     = 64'h0;
    need         = '{0, 0, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   64'(launch_busy), 64'd0);
    check("rst_done",   64'(launch_done), 64'd0);
    check("rst_err",    64'(launch_err), 64'd0);
    check("rst_dmask",  64'(done_mask), 64'd0);
    check("rst_rstart", 64'(sched_bus.sched_rstart), 64'd0);
    check("rst_wstart", 64'(sched_bus.sched_wstart), 64'd0);
    check("rst_offset", sched_bus.sched_offset, 64'd0);
    check("rst_wdata",  64'(sched_bus.sched_wdata), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    // Mask 1011, every socket done on its first poll.
    need = '{1, 1, 1, 1};
    launch(4'b1011, 64'h0000_0000_1000_0000, 32'hA5);
    check("t1_busy_on_accept", 64'(launch_busy), 64'd1);
    wait_done(400, "t1_done_seen");
    check("t1_ndone", 64'(n_done), 64'd1);
    check("t1_nwr",   64'(wr_ofs.size()), 64'd3);
    check("t1_wr0",   wr_ofs[0], 64'h1000_0000);
    check("t1_wr1",   wr_ofs[1], 64'h1001_0000);
    check("t1_wr2",   wr_ofs[2], 64'h1003_0000);
    check("t1_wdat0", 64'(wr_dat[0]), 64'hA5);
    check("t1_wdat2", 64'(wr_dat[2]), 64'hA5);
    check("t1_nrd",   64'(rd_ofs.size()), 64'd3);
    check("t1_rd0",   rd_ofs[0], 64'h1000_0010);
    check("t1_rd1",   rd_ofs[1], 64'h1001_0010);
    check("t1_rd2",   rd_ofs[2], 64'h1003_0010);
    check("t1_dmask", 64'(done_mask_s), 64'hB);
    check("t1_err",   64'(done_err_s), 64'd0);
    check("t1_busy_at_done", 64'(done_busy_s), 64'd1);
    check("t1_busy_after",   64'(launch_busy), 64'd0);
    check("t1_dmask_held",   64'(done_mask), 64'hB);

    // Empty mask: no bus traffic, done two cycles after the start.
    launch(4'b0000, 64'h0000_0000_2000_0000, 32'h1);
    wait_done(50, "t2_done_seen");
    check("t2_latency", 64'(done_cyc - start_cyc), 64'd2);
    check("t2_ndone",   64'(n_done), 64'd1);
    check("t2_nwr",     64'(wr_ofs.size()), 64'd0);
    check("t2_nrd",     64'(rd_ofs.size()), 64'd0);
    check("t2_dmask",   64'(done_mask_s), 64'd0);

    // Mask 0110: socket 1 done on 3rd poll, socket 2 on 1st; stray start mid-poll.
    need = '{0, 3, 1, 0};
    launch(4'b0110, 64'h0000_0000_2000_0000, 32'h77);
    k = 0;
    while (rd_ofs.size() == 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    check("t3_first_read_seen", 64'(rd_ofs.size() != 0), 64'd1);
    @(posedge clk); #1;
    launch_start = 1'b1;
    launch_mask  = 4'hF;
    launch_base  = 64'h0000_0000_5000_0000;
    @(posedge clk); #1;
    launch_start = 1'b0;
    wait_done(600, "t3_done_seen");
    check("t3_ndone", 64'(n_done), 64'd1);
    check("t3_nwr",   64'(wr_ofs.size()), 64'd2);
    check("t3_nrd",   64'(rd_ofs.size()), 64'd4);
    check("t3_rd0",   rd_ofs[0], 64'h2001_0010);
    check("t3_rd1",   rd_ofs[1], 64'h2002_0010);
    check("t3_rd2",   rd_ofs[2], 64'h2001_0010);
    check("t3_rd3",   rd_ofs[3], 64'h2001_0010);
    min_gap = 1000;
    for (int i = 1; i < rd_cyc.size(); i++) begin
      if (rd_cyc[i] - rd_cyc[i-1] < min_gap) min_gap = rd_cyc[i] - rd_cyc[i-1];
    end
    check("t3_gap_ge_4", 64'(min_gap >= 4), 64'd1);
    check("t3_dmask",    64'(done_mask_s), 64'h6);
    check("t3_err",      64'(done_err_s), 64'd0);

    // Socket never done: poll budget of 5 exhausted.
    need = '{0, 0, 0, 0};
    launch(4'b0001, 64'h0000_0000_3000_0000, 32'h9);
    wait_done(800, "t4_done_seen");
    check("t4_nrd",      64'(rd_ofs.size()), 64'd5);
    check("t4_rd4",      rd_ofs[4], 64'h3000_0010);
    check("t4_err",      64'(done_err_s), 64'd1);
    check("t4_dmask",    64'(done_mask_s), 64'd0);
    check("t4_ndone",    64'(n_done), 64'd1);
    check("t4_err_held", 64'(launch_err), 64'd1);

    // Asynchronous reset while a control write is outstanding.
    need = '{1, 1, 1, 1};
    launch(4'hF, 64'h0000_0000_4000_0000, 32'h5A);
    k = 0;
    while (wr_ofs.size() == 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    check("t5_write_seen", 64'(wr_ofs.size() != 0), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("t5_rst_busy",   64'(launch_busy), 64'd0);
    check("t5_rst_offset", sched_bus.sched_offset, 64'd0);
    check("t5_rst_wdata",  64'(sched_bus.sched_wdata), 64'd0);
    check("t5_rst_wstart", 64'(sched_bus.sched_wstart), 64'd0);
    @(posedge clk); #1;
    check("t5_rst_busy_hold", 64'(launch_busy), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    // Fresh launch after reset; address wraps past 2^64.
    need = '{0, 1, 0, 0};
    launch(4'b0010, 64'hFFFF_FFFF_FFFF_0000, 32'h1234_5678);
    wait_done(400, "t6_done_seen");
    check("t6_nwr",   64'(wr_ofs.size()), 64'd1);
    check("t6_wr0",   wr_ofs[0], 64'h0);
    check("t6_wdat",  64'(wr_dat[0]), 64'h1234_5678);
    check("t6_rd0",   rd_ofs[0], 64'h10);
    check("t6_dmask", 64'(done_mask_s), 64'h2);
    check("t6_err",   64'(done_err_s), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
